hamming_engine: RTL and testbench

HAMMING_ENGINE -- requirements
Module: hamming_engine

---
 rtl/hamming_pkg.sv | 13 +
 rtl/hamming_engine_popcnt_chunk.sv | 17 +
 rtl/hamming_engine.sv | 110 +++++++++++
 tb/tb_hamming_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types for the Hamming weight/distance engine: FSM states and mode encodings.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_WEIGHT = 1'b0;
    localparam logic MODE_DIST   = 1'b1;

endpackage

// File: rtl/hamming_engine_popcnt_chunk.sv
// Combinational population count of one CHUNK-bit slice.
module popcnt_chunk #(
    parameter int CHUNK = 8,
    localparam int OW   = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] in,
    output logic [OW-1:0]    out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < CHUNK; i++) begin
            out = out + OW'(in[i]);
        end
    end

endmodule

// File: rtl/hamming_engine.sv
// Multi-cycle Hamming weight / distance engine, CHUNK bits per clock.
// Optional HAMMING_EARLY_EXIT_EN: finish as soon as the remaining operand bits are all zero.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | counting one chunk per cycle
// DONE  | result presented, waiting for out_ready
module hamming_engine
    import hamming_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  CHUNK = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int PC_W   = $clog2(CHUNK + 1);
    localparam int CC_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t            state;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  sr_next;
    logic [WIDTH-1:0]  operand;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_next;
    logic [CC_W-1:0]   chunk_cnt;
    logic [PC_W-1:0]   pc;
    logic              last_chunk;
    logic              finish;

    popcnt_chunk #(.CHUNK(CHUNK)) u_popcnt (
        .in  (sr[CHUNK-1:0]),
        .out (pc)
    );

    assign operand    = (mode == MODE_DIST) ? (a ^ b) : a;
    assign sr_next    = sr >> CHUNK;
    assign acc_next   = acc + CNT_W'(pc);
    assign last_chunk = (chunk_cnt == CC_W'(NCHUNK - 1));

`ifdef HAMMING_EARLY_EXIT_EN
    assign finish = last_chunk || (sr_next == '0);
`else
    assign finish = last_chunk;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            acc       <= '0;
            chunk_cnt <= '0;
            out_valid <= 1'b0;
            count     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sr        <= operand;
                        acc       <= '0;
                        chunk_cnt <= '0;
                        state     <= BUSY;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                BUSY: begin
                    acc       <= acc_next;
                    sr        <= sr_next;
                    chunk_cnt <= chunk_cnt + 1'b1;
                    if (finish) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        count     <= acc_next;
                    end
                end
                DONE: begin
                    // in_ready stays low on the handshake edge; the next accept waits one IDLE cycle
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_engine.sv
// Scoreboard bench for hamming_engine (WIDTH=32, CHUNK=8); honours HAMMING_EARLY_EXIT_EN for latency.
module tb_hamming_engine;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        int cnt;
        int acc_cyc;
        int lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] count;
    logic             busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   last_cnt = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    hamming_engine #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected latency from the accept edge to out_valid
    function automatic int lat_of(input logic [WIDTH-1:0] x);
`ifdef HAMMING_EARLY_EXIT_EN
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (((x >> (i * CHUNK)) & {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}}) != '0) return i + 1;
        end
        return 1;
`else
        return NCHUNK + (x == x ? 0 : 1);
`endif
    endfunction

    // Monitor: compares every presented result against the scoreboard head
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            last_cnt   = 0;
        end else begin
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (out_valid) begin
                check("in_ready_low_in_done", int'(in_ready), 0);
                check("busy_in_done", int'(busy), 1);
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("count", int'(count), sb[0].cnt);
                    if (out_ready) begin
                        check("latency", rise_cyc - sb[0].acc_cyc, sb[0].lat);
                        last_cnt = sb[0].cnt;
                        void'(sb.pop_front());
                    end
                end
            end else begin
                check("count_retained", int'(count), last_cnt);
            end
            prev_valid = out_valid;
        end
    end

    task automatic issue(input logic m, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input int exp_cnt, input bit track);
        int guard;
        logic [WIDTH-1:0] opnd;
        @(negedge clk);
        in_valid = 1'b1;
        mode     = m;
        a        = xa;
        b        = xb;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("accept_timeout", guard, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~xa;
        b        = ~xb;
        mode     = ~m;
        opnd     = m ? (xa ^ xb) : xa;
        if (track) sb.push_back('{exp_cnt, cyc, lat_of(opnd)});
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        // Back-to-back directed vectors with out_ready held high
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32, 1'b1);
        issue(1'b1, 32'h0F0F_0000, 32'h0000_000F, 12, 1'b1);
        issue(1'b0, 32'h0F0F_0000, 32'h0000_000F, 8,  1'b1);
        issue(1'b0, 32'h0000_00FF, 32'hFFFF_FFFF, 8,  1'b1);
        issue(1'b0, 32'h0000_0000, 32'h1234_5678, 0,  1'b1);
        issue(1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0,  1'b1);
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32, 1'b1);
        issue(1'b0, 32'h8000_0000, 32'h0000_0000, 1,  1'b1);
        issue(1'b1, 32'h1234_5678, 32'h0000_0000, 13, 1'b1);
        drain();

        // Consumer stall: result must hold, stray requests must be ignored
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(1'b0, 32'h00FF_00FF, 32'h0000_0000, 16, 1'b1);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("stall_valid_timeout", int'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            mode     = 1'b0;
            a        = 32'hFFFF_FFFF;
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("stall_still_valid", int'(out_valid), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset in the second BUSY cycle aborts without a result
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_count", int'(count), 0);
        check("abort_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", int'(in_ready), 1);
        repeat (8) @(negedge clk);
        check("abort_no_result", int'(out_valid), 0);

        // Engine still works after the abort
        issue(1'b1, 32'hF000_000F, 32'h0000_0000, 8, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
